// File: rtl/demux_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : demux_burst_scheduler
// Brief    : Round-robin burst scheduler driving a shared 1-to-4 demux.
//            Each eligible channel receives BURST_LEN words per grant, with
//            a one-cycle break-before-make gap (SETUP) on every select change.
// Revision : 1.0 - initial release
// ============================================================================
module demux_burst_scheduler #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [3:0]        chan_mask,
    input  logic [3:0]        out_ready,
    output logic [1:0]        sel,
    output logic              demux_en,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              burst_done,
    output logic              busy
);

    localparam int               CNT_W  = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       w_grant;
    logic [1:0]       w_cand;
    logic             w_grant_ok;
    logic             w_xfer;

    // Round-robin pick: first eligible channel after the last grant. The scan
    // runs from the farthest candidate down so the nearest one wins.
    always_comb begin
        w_grant    = r_ptr;
        w_cand     = '0;
        w_grant_ok = 1'b0;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_ptr + 2'(k);
            if (chan_mask[w_cand]) begin
                w_grant    = w_cand;
                w_grant_ok = 1'b1;
            end
        end
    end

    // Next-state and output decode; data path is a pure pass-through in XFER.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        demux_en    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 4'b0000;
        out_data    = '0;
        burst_done  = 1'b0;
        busy        = 1'b0;
        w_xfer      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (in_valid && w_grant_ok) begin
                    w_ptr_nxt   = w_grant;
                    w_sel_nxt   = w_grant;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                // Select has changed; keep the demux disabled while it settles.
                busy        = 1'b1;
                w_state_nxt = S_XFER;
            end
            S_XFER: begin
                busy             = 1'b1;
                demux_en         = 1'b1;
                in_ready         = out_ready[r_sel];
                out_valid[r_sel] = in_valid;
                out_data         = in_data;
                w_xfer           = in_valid && out_ready[r_sel];
                if (w_xfer) begin
                    if (r_cnt == C_LAST) begin
                        burst_done  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else if (!chan_mask[r_sel]) begin
                    // Channel withdrawn mid-burst: drop the rest of the burst.
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers; ptr resets to 3 so the first grant lands on channel 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sel   <= 2'd0;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign sel = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_demux_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_burst_scheduler
// Brief    : Directed and randomized bench for demux_burst_scheduler, checked
//            every cycle against a burst-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_burst_scheduler;

    localparam int DATA_W    = 8;
    localparam int BURST_LEN = 4;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [3:0]        chan_mask;
    logic [3:0]        out_ready;
    logic [1:0]        sel;
    logic              demux_en;
    logic [3:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic              burst_done;
    logic              busy;

    demux_burst_scheduler #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .chan_mask (chan_mask),
        .out_ready (out_ready),
        .sel       (sel),
        .demux_en  (demux_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .burst_done(burst_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the demux, whether the select is still
    // settling, how many words of the burst remain, and the last grant.
    int m_owner  = -1;
    bit m_settle = 1'b0;
    int m_left   = 0;
    int m_last   = 3;
    int m_sel    = 0;

    logic [DATA_W-1:0] data_seq = '0;
    bit                route_chk = 1'b0;
    logic [3:0]        forbid = 4'b0000;
    int                exp_grants[$];
    int                n_done  = 0;
    int                n_words = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_grant(input int last, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) begin
            if (m[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
    task automatic tick(input logic v, input logic [3:0] m, input logic [3:0] r, input logic rs);
        bit             e_busy, e_en, e_rdy, e_xfer, e_done;
        logic [3:0]     e_ov;
        logic [DATA_W-1:0] e_od;
        int             g;
        in_valid  = v;
        chan_mask = m;
        out_ready = r;
        rst_n     = rs;
        in_data   = data_seq;
        @(negedge clk);
        e_busy = (m_owner >= 0);
        e_en   = e_busy && !m_settle;
        e_rdy  = e_en ? r[m_owner[1:0]] : 1'b0;
        e_xfer = e_rdy && v;
        e_ov   = (e_en && v) ? (4'b0001 << m_owner[1:0]) : 4'b0000;
        e_od   = e_en ? data_seq : '0;
        e_done = e_xfer && (m_left == 1);
        chk("sel",        32'(sel),        32'(m_sel));
        chk("demux_en",   32'(demux_en),   32'(e_en));
        chk("in_ready",   32'(in_ready),   32'(e_rdy));
        chk("out_valid",  32'(out_valid),  32'(e_ov));
        chk("out_data",   32'(out_data),   32'(e_od));
        chk("burst_done", 32'(burst_done), 32'(e_done));
        chk("busy",       32'(busy),       32'(e_busy));
        if (route_chk && e_xfer)
            chk("route", 32'(out_valid), 32'(4'b0001 << data_seq[3:2]));
        if (forbid != 4'b0000)
            chk("forbidden_chan", 32'(out_valid & forbid), 32'd0);
        if (e_busy && m_settle && exp_grants.size() > 0)
            chk("grant_order", 32'(sel), 32'(exp_grants.pop_front()));
        if (burst_done) n_done++;
        if ((out_valid & out_ready) != 4'b0000) n_words++;
        if (e_xfer) data_seq = data_seq + 1'b1;
        @(posedge clk);
        if (!rs) begin
            m_owner = -1; m_settle = 1'b0; m_left = 0; m_last = 3; m_sel = 0;
        end else if (m_owner < 0) begin
            g = next_grant(m_last, m);
            if (v && g >= 0) begin
                m_owner = g; m_last = g; m_sel = g; m_settle = 1'b1; m_left = BURST_LEN;
            end
        end else if (m_settle) begin
            m_settle = 1'b0;
        end else if (e_xfer) begin
            m_left--;
            if (m_left == 0) m_owner = -1;
        end else if (!m[m_owner[1:0]]) begin
            m_owner = -1;
        end
        #1;
    endtask

    initial begin
        // Establish a known state before any checking.
        rst_n = 1'b0; in_valid = 1'b1; chan_mask = 4'hF; out_ready = 4'hF; in_data = '0;
        @(posedge clk); #1;

        // 1: reset held with in_valid high, then first grant goes to ch0.
        tick(1, 4'hF, 4'hF, 0);
        tick(1, 4'hF, 4'hF, 0);

        // 2: continuous streaming over all channels, four full rounds.
        data_seq = '0; route_chk = 1'b1; n_done = 0; n_words = 0;
        exp_grants = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 96; i++) tick(1, 4'hF, 4'hF, 1);
        chk("t2_done_count", 32'(n_done), 32'd16);
        chk("t2_word_count", 32'(n_words), 32'd64);
        route_chk = 1'b0;

        // 3: only channels 1 and 3 eligible.
        tick(1, 4'hF, 4'hF, 0);
        forbid = 4'b0101; exp_grants = '{1, 3, 1, 3, 1, 3};
        for (int i = 0; i < 36; i++) tick(1, 4'b1010, 4'hF, 1);
        chk("t3_grants_seen", 32'(exp_grants.size()), 32'd0);
        forbid = 4'b0000;

        // 4: backpressure on ch1 after two words.
        tick(1, 4'hF, 4'hF, 0);
        n_words = 0; n_done = 0;
        for (int i = 0; i < 4; i++) tick(1, 4'b0010, 4'hF, 1);
        for (int i = 0; i < 3; i++) tick(1, 4'b0010, 4'h0, 1);
        for (int i = 0; i < 2; i++) tick(1, 4'b0010, 4'hF, 1);
        chk("t4_words", 32'(n_words), 32'd4);
        chk("t4_done", 32'(n_done), 32'd1);

        // 5: ch2 withdrawn during a stall, then ch3 next, then empty mask.
        tick(1, 4'hF, 4'hF, 0);
        n_done = 0; exp_grants = '{2, 3};
        tick(1, 4'b0100, 4'hF, 1);
        tick(1, 4'b0100, 4'hF, 1);
        tick(1, 4'b0100, 4'h0, 1);
        tick(1, 4'b0100, 4'h0, 1);
        tick(1, 4'b1000, 4'h0, 1);
        chk("t5_abort_no_done", 32'(n_done), 32'd0);
        for (int i = 0; i < 6; i++) tick(1, 4'hF, 4'hF, 1);
        for (int i = 0; i < 4; i++) tick(1, 4'h0, 4'hF, 1);
        chk("t5_done", 32'(n_done), 32'd1);
        chk("t5_grants_seen", 32'(exp_grants.size()), 32'd0);

        // 6: reset during a ch2 burst at cnt=1; restart goes to ch0.
        tick(1, 4'hF, 4'hF, 0);
        tick(1, 4'b0100, 4'hF, 1);
        tick(1, 4'b0100, 4'hF, 1);
        tick(1, 4'b0100, 4'hF, 1);
        tick(1, 4'b0100, 4'hF, 0);
        exp_grants = '{0};
        for (int i = 0; i < 6; i++) tick(1, 4'hF, 4'hF, 1);
        chk("t6_grants_seen", 32'(exp_grants.size()), 32'd0);

        // Randomized traffic, mask churn and occasional resets.
        exp_grants.delete();
        begin
            logic [3:0] rm;
            rm = 4'hF;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 19) == 0) rm = 4'($urandom);
                data_seq = DATA_W'($urandom);
                tick(($urandom_range(0, 9) < 7), rm, 4'($urandom | $urandom),
                     ($urandom_range(0, 199) != 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
